// File: rtl/spi_dac_multi.sv
// rtl/spi_dac_multi.sv - multi-channel SPI DAC frame serializer
//
// Purpose: accepts (CH, DATA) requests into a one-deep holding register and
// shifts each word out MSB first to the selected DAC over SCLK/SDO, with a
// per-channel active-low chip select and a minimum CS-high gap between frames.
//
// Ports:
//    CLK      in   system clock, rising edge
//    RESET_N  in   asynchronous active-low reset
//    TR       in   request strobe, taken when READY=1
//    CH       in   target channel, sampled with TR
//    DATA     in   frame word, sampled with TR
//    READY    out  holding register empty
//    DA_CS    out  per-channel chip select, active-low
//    DA_SCLK  out  serial clock, idle low
//    DA_SDO   out  serial data, MSB first
//    BUSY     out  frame accepted, running or in CS gap
//    DONE     out  one-cycle pulse on the cycle CS returns high
//    ERR      out  one-cycle pulse for a request with CH >= CH_N

module spi_dac_multi #(
   parameter int DATA_W  = 24,
   parameter int CH_N    = 2,
   parameter int CLK_DIV = 2,
   parameter int CS_GAP  = 2,
   parameter int CH_W    = (CH_N > 1) ? $clog2(CH_N) : 1
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              TR,
   input  logic [CH_W-1:0]   CH,
   input  logic [DATA_W-1:0] DATA,
   output logic              READY,
   output logic [CH_N-1:0]   DA_CS,
   output logic              DA_SCLK,
   output logic              DA_SDO,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR
);

   localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BIT_W   = $clog2(DATA_W + 1);

   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_SCLK_H = 3'd2,
      S_SCLK_L = 3'd3,
      S_HOLD   = 3'd4,
      S_GAP    = 3'd5
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic              armed;
   logic              hold_full;
   logic [CH_W-1:0]   hold_ch;
   logic [DATA_W-1:0] hold_data;
   logic [CH_W-1:0]   cur_ch;
   logic [DATA_W-1:0] shift_reg;
   logic [CNT_W-1:0]  cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic              err_q;
   logic              cs_active;

   logic [31:0]       ch_ext;
   logic              ch_ok;
   logic              req_take;
   logic              accept;
   logic              reject;
   logic              load;
   logic              phase_end;
   logic              gap_end;

   assign ch_ext    = 32'(CH);
   assign ch_ok     = (ch_ext < 32'(CH_N));
   // armed stays low for the first edge after reset release, so a TR that
   // is already high while reset lifts is not taken as a request.
   assign req_take  = TR && !hold_full && armed;
   assign accept    = req_take && ch_ok;
   assign reject    = req_take && !ch_ok;
   assign load      = (state == S_IDLE) && hold_full;
   assign phase_end = (cnt == DIV_LAST);
   assign gap_end   = (cnt == GAP_LAST);

   assign READY = !hold_full;
   assign BUSY  = hold_full || (state != S_IDLE);
   assign ERR   = err_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The last SCLK high phase goes straight to HOLD: HOLD doubles as the
   // final low half-period, which gives CS low for CLK_DIV*(2*DATA_W+1).
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (hold_full) state_nxt = S_SETUP;
         S_SETUP:  if (phase_end) state_nxt = S_SCLK_H;
         S_SCLK_H: if (phase_end) state_nxt = (bit_cnt == BIT_LAST) ? S_HOLD : S_SCLK_L;
         S_SCLK_L: if (phase_end) state_nxt = S_SCLK_H;
         S_HOLD:   if (phase_end) state_nxt = S_GAP;
         S_GAP:    if (gap_end)   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cs_active = 1'b0;
      DONE      = 1'b0;
      DA_CS     = '1;
      case (state)
         S_SETUP, S_SCLK_H, S_SCLK_L, S_HOLD: cs_active = 1'b1;
         S_GAP:   DONE = (cnt == '0);
         default: ;
      endcase
      DA_SCLK = (state == S_SCLK_H);
      for (int i = 0; i < CH_N; i++) begin
         if (cs_active && (cur_ch == CH_W'(i))) DA_CS[i] = 1'b0;
      end
      DA_SDO = cs_active & shift_reg[DATA_W-1];
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         armed     <= 1'b0;
         hold_full <= 1'b0;
         hold_ch   <= '0;
         hold_data <= '0;
         cur_ch    <= '0;
         shift_reg <= '0;
         cnt       <= '0;
         bit_cnt   <= '0;
         err_q     <= 1'b0;
      end else begin
         armed <= 1'b1;
         err_q <= reject;

         // Phase counter restarts on every state change.
         if ((state_nxt != state) || (state == S_IDLE)) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end

         // accept needs an empty holder and load needs a full one, so the
         // two never coincide.
         if (load) begin
            hold_full <= 1'b0;
         end else if (accept) begin
            hold_full <= 1'b1;
            hold_ch   <= CH;
            hold_data <= DATA;
         end

         if (load) begin
            shift_reg <= hold_data;
            cur_ch    <= hold_ch;
            bit_cnt   <= '0;
         end else if ((state == S_SCLK_H) && phase_end && (bit_cnt != BIT_LAST)) begin
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_dac_multi.sv
// tb/tb_spi_dac_multi.sv - self-checking bench for spi_dac_multi
//
// Purpose: drives two instances (24-bit/CLK_DIV=2/2 channels with a 2-bit CH
// port, and 16-bit/CLK_DIV=1/4 channels) and compares captured SPI frames
// against a queue of accepted requests.
//
// Ports: none.

module tb_spi_dac_multi;

   localparam int W_A = 24, DIV_A = 2, GAP_A = 2, CHN_A = 2;
   localparam int W_B = 16, DIV_B = 1, GAP_B = 3, CHN_B = 4;

   typedef struct {
      logic [31:0] data;
      int          ch;
      int          len;
      int          rises;
   } frame_t;

   logic        clk;
   logic        rst_n;

   logic        tr_a, ready_a, sclk_a, sdo_a, busy_a, done_a, err_a;
   logic [1:0]  ch_a;
   logic [23:0] data_a;
   logic [1:0]  cs_a;

   logic        tr_b, ready_b, sclk_b, sdo_b, busy_b, done_b, err_b;
   logic [1:0]  ch_b;
   logic [15:0] data_b;
   logic [3:0]  cs_b;

   int checks;
   int failures;

   frame_t got0[$], got1[$], exp0[$], exp1[$];
   int     gap0[$], gap1[$];

   int          lowc[2], rises[2], hic[2], done_cnt[2], viol[2], fch[2];
   bit          prev_lo[2], prev_sc[2], seen[2];
   logic [7:0]  fcs[2];
   logic [31:0] acc[2];

   spi_dac_multi #(.DATA_W(W_A), .CH_N(CHN_A), .CLK_DIV(DIV_A), .CS_GAP(GAP_A), .CH_W(2)) u_a (
      .CLK(clk), .RESET_N(rst_n), .TR(tr_a), .CH(ch_a), .DATA(data_a), .READY(ready_a),
      .DA_CS(cs_a), .DA_SCLK(sclk_a), .DA_SDO(sdo_a), .BUSY(busy_a), .DONE(done_a), .ERR(err_a)
   );

   spi_dac_multi #(.DATA_W(W_B), .CH_N(CHN_B), .CLK_DIV(DIV_B), .CS_GAP(GAP_B)) u_b (
      .CLK(clk), .RESET_N(rst_n), .TR(tr_b), .CH(ch_b), .DATA(data_b), .READY(ready_b),
      .DA_CS(cs_b), .DA_SCLK(sclk_b), .DA_SDO(sdo_b), .BUSY(busy_b), .DONE(done_b), .ERR(err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int div_of(input int i);
      return (i == 0) ? DIV_A : DIV_B;
   endfunction

   // Frame monitor: reconstructs each CS-low window from the pins alone.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic [7:0] csv;
         bit         lo, sc, sd, dn;
         frame_t     f;
         csv = (i == 0) ? {6'h3f, cs_a} : {4'hf, cs_b};
         sc  = (i == 0) ? sclk_a : sclk_b;
         sd  = (i == 0) ? sdo_a : sdo_b;
         dn  = (i == 0) ? done_a : done_b;
         lo  = (csv != 8'hff);
         if (!rst_n) begin
            prev_lo[i] = 1'b0;
            prev_sc[i] = 1'b0;
            seen[i]    = 1'b0;
            lowc[i]    = 0;
            rises[i]   = 0;
            hic[i]     = 0;
         end else begin
            if (dn) done_cnt[i]++;
            if ($countones(~csv) > 1) viol[i]++;
            if (!lo && (sc || sd)) viol[i]++;
            if (dn != (prev_lo[i] && !lo)) viol[i]++;
            if (lo) begin
               if (!prev_lo[i]) begin
                  if (seen[i]) begin
                     if (i == 0) gap0.push_back(hic[i]);
                     else        gap1.push_back(hic[i]);
                  end
                  lowc[i]  = 0;
                  rises[i] = 0;
                  acc[i]   = '0;
                  fcs[i]   = csv;
                  for (int j = 0; j < 8; j++) if (!csv[j]) fch[i] = j;
               end else if (csv != fcs[i]) begin
                  viol[i]++;
               end
               lowc[i]++;
               if (sc && !prev_sc[i]) begin
                  rises[i]++;
                  acc[i] = {acc[i][30:0], sd};
                  // k-th rise lands after the setup phase plus k-1 full periods
                  if (lowc[i] != div_of(i) * (2 * rises[i] - 1) + 1) viol[i]++;
               end
            end else begin
               if (prev_lo[i]) begin
                  f.data  = acc[i];
                  f.ch    = fch[i];
                  f.len   = lowc[i];
                  f.rises = rises[i];
                  if (i == 0) got0.push_back(f);
                  else        got1.push_back(f);
                  seen[i] = 1'b1;
                  hic[i]  = 0;
               end
               hic[i]++;
            end
            prev_lo[i] = lo;
            prev_sc[i] = sc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int inst, input int ch, input logic [31:0] data, input bit ok);
      int     n;
      frame_t e;
      n = 0;
      while (!((inst == 0) ? ready_a : ready_b) && n < 2000) begin
         tick();
         n++;
      end
      chk("send_ready_wait", n < 2000, 1'b1);
      if (inst == 0) begin
         tr_a = 1'b1; ch_a = 2'(ch); data_a = data[23:0];
      end else begin
         tr_b = 1'b1; ch_b = 2'(ch); data_b = data[15:0];
      end
      tick();
      tr_a = 1'b0;
      tr_b = 1'b0;
      e.data = data; e.ch = ch; e.len = 0; e.rises = 0;
      if (ok) begin
         if (inst == 0) exp0.push_back(e);
         else           exp1.push_back(e);
      end
   endtask

   task automatic wait_frames(input int inst, input int n);
      int k;
      k = 0;
      while (((inst == 0) ? got0.size() : got1.size()) < n && k < 5000) begin
         tick();
         k++;
      end
      chk("frames_arrived", (inst == 0) ? got0.size() : got1.size(), n);
   endtask

   task automatic check_frames(input int inst, input int n);
      frame_t g, e;
      int     len, w;
      for (int k = 0; k < n; k++) begin
         if (inst == 0) begin
            if (got0.size() == 0 || exp0.size() == 0) break;
            g = got0.pop_front(); e = exp0.pop_front();
            len = DIV_A * (2 * W_A + 1); w = W_A;
         end else begin
            if (got1.size() == 0 || exp1.size() == 0) break;
            g = got1.pop_front(); e = exp1.pop_front();
            len = DIV_B * (2 * W_B + 1); w = W_B;
         end
         chk("frame_data", g.data, e.data);
         chk("frame_ch", g.ch, e.ch);
         chk("frame_cs_low_len", g.len, len);
         chk("frame_sclk_rises", g.rises, w);
      end
   endtask

   initial begin
      int          n, k, d0, acc_n;
      bit          ps;
      logic [31:0] rd;
      checks = 0; failures = 0;
      for (int i = 0; i < 2; i++) begin
         done_cnt[i] = 0; viol[i] = 0; fch[i] = 0; acc[i] = '0; fcs[i] = 8'hff;
      end
      rst_n = 1'b0;
      tr_a = 1'b0; ch_a = '0; data_a = '0;
      tr_b = 1'b0; ch_b = '0; data_b = '0;
      tick(); tick();

      // Reset values
      chk("rst_cs_a", cs_a, 2'b11);
      chk("rst_cs_b", cs_b, 4'hf);
      chk("rst_sclk", {sclk_a, sclk_b}, 2'b00);
      chk("rst_sdo", {sdo_a, sdo_b}, 2'b00);
      chk("rst_ready", {ready_a, ready_b}, 2'b11);
      chk("rst_busy_done_err", {busy_a, done_a, err_a, busy_b, done_b, err_b}, 6'b0);

      // TR already high as reset lifts must not be taken
      tr_a = 1'b1; ch_a = 2'd0; data_a = 24'h123456;
      rst_n = 1'b1;
      tick();
      tr_a = 1'b0;
      tick();
      chk("first_cycle_tr_ignored_busy", busy_a, 1'b0);
      chk("first_cycle_tr_ignored_ready", ready_a, 1'b1);
      repeat (5) tick();
      chk("first_cycle_tr_no_frame", got0.size(), 0);

      // Single frame, channel 0
      d0 = done_cnt[0];
      send(0, 0, 32'hA5F00F, 1'b1);
      chk("busy_after_accept", busy_a, 1'b1);
      wait_frames(0, 1);
      check_frames(0, 1);
      repeat (6) tick();
      chk("done_one_pulse", done_cnt[0] - d0, 1);
      chk("busy_idle_after_gap", busy_a, 1'b0);

      // Second request while the first frame is in flight
      send(0, 1, 32'h000001, 1'b1);
      n = 0;
      while (cs_a == 2'b11 && n < 200) begin tick(); n++; end
      repeat (10) tick();
      chk("busy_mid_frame", busy_a, 1'b1);
      send(0, 0, 32'hFFFFFF, 1'b1);
      chk("ready_low_after_second_accept", ready_a, 1'b0);
      wait_frames(0, 2);
      check_frames(0, 2);
      chk("back_to_back_gap", (gap0.size() > 0) ? gap0[gap0.size()-1] : -1, GAP_A + 1);

      // Out-of-range channels: CH == CH_N and CH > CH_N
      repeat (8) tick();
      for (int c = CHN_A; c < 4; c++) begin
         ch_a = 2'(c); data_a = 24'hC0FFEE; tr_a = 1'b1;
         tick();
         tr_a = 1'b0;
         chk("err_pulse", err_a, 1'b1);
         chk("err_ready_kept", ready_a, 1'b1);
         chk("err_not_busy", busy_a, 1'b0);
         tick();
         chk("err_one_cycle", err_a, 1'b0);
      end
      repeat (10) tick();
      chk("err_no_cs", cs_a, 2'b11);
      chk("err_no_frame", got0.size(), 0);

      // Reset asserted right at the 10th SCLK rise
      rd = $urandom & 32'hFFFFFF;
      send(0, 1, rd, 1'b1);
      k = 0; n = 0; ps = sclk_a;
      while (k < 10 && n < 1000) begin
         tick();
         if (sclk_a && !ps) k++;
         ps = sclk_a;
         n++;
      end
      chk("rst_mid_rise10_reached", k, 10);
      d0 = done_cnt[0];
      rst_n = 1'b0;
      #1;
      chk("rst_mid_cs_async", cs_a, 2'b11);
      chk("rst_mid_sclk_sdo", {sclk_a, sdo_a}, 2'b00);
      chk("rst_mid_ready", ready_a, 1'b1);
      chk("rst_mid_busy_done", {busy_a, done_a}, 2'b00);
      exp0.delete();
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      chk("rst_mid_no_done", done_cnt[0], d0);
      chk("rst_mid_no_frame", got0.size(), 0);
      rd = $urandom & 32'hFFFFFF;
      send(0, 0, rd, 1'b1);
      wait_frames(0, 1);
      check_frames(0, 1);

      // TR held high: every accepted strobe yields exactly one frame
      repeat (8) tick();
      tr_a = 1'b1; ch_a = 2'($urandom_range(0, 1)); data_a = 24'($urandom);
      acc_n = 0; n = 0;
      while (acc_n < 4 && n < 3000) begin
         if (ready_a) begin
            begin
               frame_t e;
               e.data = {8'h0, data_a}; e.ch = ch_a; e.len = 0; e.rises = 0;
               exp0.push_back(e);
            end
            acc_n++;
            tick();
            ch_a = 2'($urandom_range(0, 1)); data_a = 24'($urandom);
         end else begin
            tick();
         end
         n++;
      end
      tr_a = 1'b0;
      chk("held_tr_accepts", acc_n, 4);
      wait_frames(0, 4);
      check_frames(0, 4);
      repeat (150) tick();
      chk("held_tr_no_extra", got0.size(), 0);

      // Narrow, fast instance with random channels and data
      for (int j = 0; j < 6; j++) begin
         send(1, $urandom_range(0, CHN_B - 1), 32'($urandom_range(0, 16'hFFFF)), 1'b1);
      end
      wait_frames(1, 6);
      check_frames(1, 6);
      chk("b_gap_count", gap1.size(), 5);
      while (gap1.size() > 0) chk("b_gap_len", gap1.pop_front(), GAP_B + 1);

      repeat (10) tick();
      chk("a_pin_invariants", viol[0], 0);
      chk("b_pin_invariants", viol[1], 0);
      chk("a_expected_drained", exp0.size(), 0);
      chk("b_expected_drained", exp1.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
